// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter.
//
// Accepts a WIDTH-bit word on a load/ready handshake and shifts it out one
// bit per clock. sout is qualified by sout_valid. done pulses for one cycle
// after the last bit of each word.
//
// Ports:
//   clk         rising-edge clock, sole clock domain
//   rst_        synchronous, active-high reset
//   data        parallel word, captured only on the accepting edge
//   load        load request, honoured only while ready=1
//   ready       transmitter idle and able to accept a load (registered)
//   sout        serial data bit, 0 whenever sout_valid=0 (registered)
//   sout_valid  sout carries a valid bit this cycle (registered)
//   done        one-cycle pulse after the last bit of a word (registered)
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    cnt_reg,   cnt_next;
  logic             sout_reg,  sout_next;
  logic             valid_reg, valid_next;
  logic             done_reg,  done_next;
  logic             ready_reg, ready_next;

  // Reorder the input word so the first bit to transmit always sits at the
  // top; the datapath then only ever shifts left regardless of bit order.
  logic [WIDTH-1:0] tx_order;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign tx_order[gi] = data[gi];
      end else begin : g_lsb
        assign tx_order[gi] = data[WIDTH-1-gi];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    sout_next  = sout_reg;
    valid_next = valid_reg;
    done_next  = done_reg;
    ready_next = ready_reg;

    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        sout_next  = 1'b0;
        valid_next = 1'b0;
        done_next  = 1'b0;
        if (load) begin
          // First bit leaves immediately; the rest wait in the shifter.
          sout_next  = tx_order[WIDTH-1];
          valid_next = 1'b1;
          ready_next = 1'b0;
          cnt_next   = CW'(1);
          shift_next = {tx_order[WIDTH-2:0], 1'b0};
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_reg < CW'(WIDTH)) begin
          sout_next  = shift_reg[WIDTH-1];
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          cnt_next   = cnt_reg + CW'(1);
          valid_next = 1'b1;
        end else begin
          // All WIDTH bits have been presented: close the word.
          sout_next  = 1'b0;
          valid_next = 1'b0;
          done_next  = 1'b1;
          ready_next = 1'b1;
          cnt_next   = '0;
          shift_next = '0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      sout_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      sout_reg  <= sout_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
    end
  end

  assign ready      = ready_reg;
  assign sout       = sout_reg;
  assign sout_valid = valid_reg;
  assign done       = done_reg;

endmodule
